// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline stage registers.
//   DEF_EXC_W       default exception-code width
//   DEF_HANDLER_PC  default PC presented on an exception redirect
//   EXC_*           exception-code values carried in the exccode field
//   pipe_state_e    occupancy state of a stage buffer (EMPTY/ONE/TWO)
//   stage_meta_t    pc/exccode/bd bundle at the default widths
package pipe_pkg;

  localparam int          DEF_EXC_W      = 5;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  localparam logic [DEF_EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [DEF_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [DEF_EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [DEF_EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [DEF_EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [DEF_EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [DEF_EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic [DEF_EXC_W-1:0] exccode;
    logic                 bd;
  } stage_meta_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline boundary register with valid/ready handshake,
// flush and exception redirect.
//
// Build option: PIPE_SKID_EN
//   defined   - 2-entry skid buffer, s_ready registered (no m_ready->s_ready path)
//   undefined - single register, s_ready = m_ready || !m_valid
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   s_valid/s_ready            upstream handshake
//   s_pc/s_payload/s_exccode/s_bd  upstream entry fields
//   flush                      discard all entries, outputs cleared
//   req                        discard all entries, present redirect bubble
//   m_valid/m_ready            downstream handshake
//   m_pc/m_payload/m_exccode/m_bd  downstream entry fields
//
// state | meaning
// EMPTY | no entry held, m_valid=0
// ONE   | main register holds the head entry
// TWO   | main holds head, skid holds the next entry (skid build only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 128,
  parameter int          EXC_W      = DEF_EXC_W,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_pc,
  input  logic [PAYLOAD_W-1:0] s_payload,
  input  logic [EXC_W-1:0]     s_exccode,
  input  logic                 s_bd,
  input  logic                 flush,
  input  logic                 req,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_pc,
  output logic [PAYLOAD_W-1:0] m_payload,
  output logic [EXC_W-1:0]     m_exccode,
  output logic                 m_bd
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [31:0]          pc;
    logic [EXC_W-1:0]     exccode;
    logic                 bd;
  } entry_t;

  pipe_state_e state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      in_entry;
  entry_t      redir_entry;
  logic        push, pop;

  assign in_entry    = '{payload: s_payload, pc: s_pc, exccode: s_exccode, bd: s_bd};
  assign redir_entry = '{payload: '0, pc: HANDLER_PC, exccode: '0, bd: 1'b0};

  assign m_valid   = (state_q != EMPTY);
  assign m_pc      = main_q.pc;
  assign m_payload = main_q.payload;
  assign m_exccode = main_q.exccode;
  assign m_bd      = main_q.bd;

`ifdef PIPE_SKID_EN
  entry_t skid_q, skid_d;
  logic   s_ready_q, s_ready_d;

  assign s_ready = s_ready_q;
`else
  assign s_ready = m_ready || !m_valid;
`endif

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    // req and flush both drop any concurrent push; req wins over flush.
    if (req) begin
      state_d = EMPTY;
      main_d  = redir_entry;
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
    end else if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
`ifdef PIPE_SKID_EN
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // s_ready is low here, so only a pop can happen.
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
`else
      if (push) begin
        main_d  = in_entry;
        state_d = ONE;
      end else if (pop) begin
        state_d = EMPTY;
      end
`endif
    end
  end

`ifdef PIPE_SKID_EN
  // Registered copy of (next state != TWO), so s_ready tracks state without
  // any combinational dependence on m_ready.
  assign s_ready_d = (state_d != TWO);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
`ifdef PIPE_SKID_EN
      skid_q    <= '0;
      s_ready_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
`ifdef PIPE_SKID_EN
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam logic [31:0] HPC = 32'h0000_4180;

  logic         clk;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_pc;
  logic [127:0] s_payload;
  logic [4:0]   s_exccode;
  logic         s_bd;
  logic         flush;
  logic         req;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_pc;
  logic [127:0] m_payload;
  logic [4:0]   m_exccode;
  logic         m_bd;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(
    .PAYLOAD_W (128),
    .EXC_W     (5),
    .HANDLER_PC(HPC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pc     (s_pc),
    .s_payload(s_payload),
    .s_exccode(s_exccode),
    .s_bd     (s_bd),
    .flush    (flush),
    .req      (req),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_pc     (m_pc),
    .m_payload(m_payload),
    .m_exccode(m_exccode),
    .m_bd     (m_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of held entries plus the value the output
  // registers show when nothing is held.
  typedef struct {
    logic [31:0]  pc;
    logic [127:0] pl;
    logic [4:0]   exc;
    logic         bd;
  } ent_t;

  ent_t q[$];
  ent_t disp;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  function automatic bit exp_sready(input bit mr);
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || mr;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t e;
    e = (q.size() > 0) ? q[0] : disp;
    chk({tag, "_m_valid"},   128'(m_valid),   128'(q.size() > 0));
    chk({tag, "_s_ready"},   128'(s_ready),   128'(exp_sready(m_ready)));
    chk({tag, "_m_pc"},      128'(m_pc),      128'(e.pc));
    chk({tag, "_m_payload"}, m_payload,       e.pl);
    chk({tag, "_m_exccode"}, 128'(m_exccode), 128'(e.exc));
    chk({tag, "_m_bd"},      128'(m_bd),      128'(e.bd));
  endtask

  // One cycle: drive at negedge, check, model the edge, return at next negedge.
  task automatic step(input string tag, input bit sv, input logic [31:0] pc,
                      input bit mr, input bit fl, input bit rq);
    ent_t ne;
    bit   push, pop;
    ne.pc  = pc;
    ne.pl  = {$urandom, $urandom, $urandom, $urandom};
    ne.exc = 5'($urandom_range(0, 31));
    ne.bd  = 1'($urandom_range(0, 1));
    s_valid   = sv;
    s_pc      = ne.pc;
    s_payload = ne.pl;
    s_exccode = ne.exc;
    s_bd      = ne.bd;
    m_ready   = mr;
    flush     = fl;
    req       = rq;
    #1;
    check_all(tag);
    push = sv && exp_sready(mr);
    pop  = (q.size() > 0) && mr;
    @(posedge clk);
    if (rq) begin
      q.delete();
      disp = '{pc: HPC, pl: '0, exc: '0, bd: 1'b0};
    end else if (fl) begin
      q.delete();
      disp = '{pc: '0, pl: '0, exc: '0, bd: 1'b0};
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ne);
      if (q.size() > 0) disp = q[0];
    end
    @(negedge clk);
  endtask

  initial begin
    s_valid = 0; s_pc = '0; s_payload = '0; s_exccode = '0; s_bd = 0;
    flush = 0; req = 0; m_ready = 1;
    disp = '{pc: '0, pl: '0, exc: '0, bd: 1'b0};
    reset = 0;
    repeat (3) @(negedge clk);
    #1;
    check_all("reset");
    reset = 1;
    @(negedge clk);

    // Streaming at full rate
    step("str0", 1, 32'h3000, 1, 0, 0);
    step("str1", 1, 32'h3004, 1, 0, 0);
    step("str2", 1, 32'h3008, 1, 0, 0);
    step("str3", 0, 32'h0,    1, 0, 0);
    step("str4", 0, 32'h0,    1, 0, 0);

    // Backpressure: skid absorbs one extra, single build stalls at once
    step("bp0", 1, 32'h3000, 0, 0, 0);
    step("bp1", 1, 32'h3004, 0, 0, 0);
    step("bp2", 1, 32'h3008, 0, 0, 0);
    step("bp3", 0, 32'h0,    0, 0, 0);
    step("bp4", 0, 32'h0,    1, 0, 0);
    step("bp5", 0, 32'h0,    1, 0, 0);
    step("bp6", 0, 32'h0,    1, 0, 0);

    // Exception redirect while full, with a concurrent push
    step("ex0", 1, 32'h3100, 0, 0, 0);
    step("ex1", 1, 32'h3104, 0, 0, 0);
    step("ex2", 1, 32'h3108, 0, 0, 1);
    step("ex3", 0, 32'h0,    0, 0, 0);
    step("ex4", 0, 32'h0,    1, 0, 0);

    // flush and req together: req wins
    step("fr0", 1, 32'h3200, 0, 0, 0);
    step("fr1", 1, 32'h3204, 1, 1, 1);
    step("fr2", 0, 32'h0,    1, 0, 0);

    // flush alone
    step("fl0", 1, 32'h3300, 0, 0, 0);
    step("fl1", 1, 32'h3304, 0, 1, 0);
    step("fl2", 0, 32'h0,    1, 0, 0);

    // Asynchronous reset mid-cycle while holding one entry
    step("ar0", 1, 32'h3020, 0, 0, 0);
    s_valid = 0; m_ready = 0; flush = 0; req = 0;
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    q.delete();
    disp = '{pc: '0, pl: '0, exc: '0, bd: 1'b0};
    check_all("ar_async");
    @(negedge clk);
    reset = 1;
    step("ar1", 1, 32'h3010, 1, 0, 0);
    step("ar2", 0, 32'h0,    1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)),
           {16'h0, 16'($urandom_range(0, 16'hFFFF))} & 32'hFFFF_FFFC,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
